// File: rtl/acq_readout_sequencer.sv
// -----------------------------------------------------------------------------
// acq_readout_sequencer
//
// Sequences one acquisition/readout cycle. An arm request pulses startTrigger
// and then waits for data_ready. It first waits for data_ready low, then for
// it to go high. It then reads nsmp samples per enabled channel out of the
// sample RAM, starting at (wraddress_triggerpoint - triggerpoint). Each
// channel's samples are preceded by a header byte {4'hA, 2'b00, chsel}. All
// bytes leave through a small skid FIFO with a valid/ready handshake.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   arm, abort, autorearm  control: start, force-idle, re-arm after DONE
//   chanmask, nsmp         channels to read, samples per channel (0 = 2^W)
//   triggerpoint,
//   wraddress_triggerpoint pre-trigger count and RAM address at trigger
//   trig_timeout           trigger wait limit in cycles (0 = forever)
//   data_ready             acquisition-complete level from the front end
//   startTrigger           one-cycle acquisition start pulse
//   rden, rdaddress, chsel sample-RAM read port; ram_q returns RD_LAT later
//   out_data/valid/ready   byte stream
//   busy, done, timed_out  status: not idle, readout complete, trigger timeout
// -----------------------------------------------------------------------------
module acq_readout_sequencer #(
    parameter int RAM_WIDTH  = 10,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 autorearm,
    input  logic [3:0]           chanmask,
    input  logic [RAM_WIDTH-1:0] nsmp,
    input  logic [RAM_WIDTH-1:0] triggerpoint,
    input  logic [RAM_WIDTH-1:0] wraddress_triggerpoint,
    input  logic [31:0]          trig_timeout,
    input  logic                 data_ready,
    output logic                 startTrigger,
    output logic                 rden,
    output logic [RAM_WIDTH-1:0] rdaddress,
    output logic [1:0]           chsel,
    input  logic [7:0]           ram_q,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 timed_out
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IW = $clog2(RD_LAT + 1);
    // nsmp == 0 stands for a full RAM's worth of samples
    localparam logic [RAM_WIDTH:0] FULL_COUNT = {1'b1, {RAM_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WAITLOW, S_WAITRDY, S_SETUP, S_READ, S_DRAIN, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            tmo_q, tmo_d;
    logic [RAM_WIDTH-1:0]   start_q, start_d;
    logic [RAM_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]             chsel_q, chsel_d;
    logic [3:0]             mask_q, mask_d;      // channels still to visit after the current one
    logic [RAM_WIDTH:0]     nsmp_q, nsmp_d;
    logic [RAM_WIDTH:0]     remain_q, remain_d;  // reads left to issue on this channel
    logic [RD_LAT-1:0]      vld_q, vld_d;        // read-return pipeline, one bit per cycle of latency
    logic [IW-1:0]          inflight_q, inflight_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          fifo_count_q, fifo_count_d;
    logic [7:0]             fifo_mem_q [FIFO_DEPTH];

    logic        rden_c, hdr_push, start_trig_c, done_c, timeout_c;
    logic [7:0]  hdr_byte, push_byte;
    logic        pipe_push, fifo_push, fifo_pop, space_ok, tmo_hit;
    logic [31:0] occupancy;

    function automatic logic [1:0] lowest_bit(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Bytes already queued plus reads whose data is still on its way must fit
    // in the FIFO, so a returning sample always has a free slot.
    assign occupancy = 32'(fifo_count_q) + 32'(inflight_q);
    assign space_ok  = occupancy < 32'(FIFO_DEPTH);
    assign tmo_hit   = (trig_timeout != 32'd0) && ((tmo_q + 32'd1) == trig_timeout);

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        start_d      = start_q;
        addr_d       = addr_q;
        chsel_d      = chsel_q;
        mask_d       = mask_q;
        nsmp_d       = nsmp_q;
        remain_d     = remain_q;
        rden_c       = 1'b0;
        hdr_push     = 1'b0;
        hdr_byte     = 8'h00;
        start_trig_c = 1'b0;
        done_c       = 1'b0;
        timeout_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arm && (chanmask != 4'b0000)) state_d = S_ARM;
            end
            S_ARM: begin
                start_trig_c = 1'b1;
                tmo_d        = 32'd0;
                state_d      = S_WAITLOW;
            end
            S_WAITLOW: begin
                tmo_d = tmo_q + 32'd1;
                if (!data_ready) begin
                    state_d = S_WAITRDY;
                end else if (tmo_hit) begin
                    timeout_c = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_WAITRDY: begin
                tmo_d = tmo_q + 32'd1;
                if (data_ready) begin
                    state_d = S_SETUP;
                end else if (tmo_hit) begin
                    timeout_c = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_SETUP: begin
                // FIFO is always empty here, so the first header needs no space check
                start_d = wraddress_triggerpoint - triggerpoint;
                addr_d  = wraddress_triggerpoint - triggerpoint;
                nsmp_d  = (nsmp == '0) ? FULL_COUNT : {1'b0, nsmp};
                remain_d = (nsmp == '0) ? FULL_COUNT : {1'b0, nsmp};
                if (chanmask != 4'b0000) begin
                    chsel_d  = lowest_bit(chanmask);
                    mask_d   = chanmask & (chanmask - 4'd1);
                    hdr_push = 1'b1;
                    hdr_byte = {4'hA, 2'b00, lowest_bit(chanmask)};
                    state_d  = S_READ;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_READ: begin
                if (remain_q != '0) begin
                    if (space_ok) begin
                        rden_c   = 1'b1;
                        addr_d   = addr_q + RAM_WIDTH'(1);
                        remain_d = remain_q - (RAM_WIDTH + 1)'(1);
                    end
                end else if (inflight_q == '0) begin
                    // chsel only moves once the channel's reads have all returned,
                    // so the ram_q mux never switches under an outstanding read
                    if (mask_q != 4'b0000) begin
                        if (fifo_count_q < CW'(FIFO_DEPTH)) begin
                            hdr_push = 1'b1;
                            hdr_byte = {4'hA, 2'b00, lowest_bit(mask_q)};
                            chsel_d  = lowest_bit(mask_q);
                            mask_d   = mask_q & (mask_q - 4'd1);
                            remain_d = nsmp_q;
                            addr_d   = start_q;
                        end
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((inflight_q == '0) && (fifo_count_q == '0)) state_d = S_DONE;
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = autorearm ? S_ARM : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d   = S_IDLE;
            rden_c    = 1'b0;
            hdr_push  = 1'b0;
            done_c    = 1'b0;
            timeout_c = 1'b0;
        end
    end

    // ------------------------------------------- read pipeline and FIFO
    always_comb begin
        vld_d[0] = rden_c;
        for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
        pipe_push = vld_q[RD_LAT-1];

        inflight_d = inflight_q;
        case ({rden_c, pipe_push})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase

        // header pushes only happen with nothing in flight, so they never collide
        fifo_push = hdr_push | pipe_push;
        push_byte = hdr_push ? hdr_byte : ram_q;
        fifo_pop  = (fifo_count_q != '0) && out_ready;

        wr_ptr_d = fifo_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = fifo_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({fifo_push, fifo_pop})
            2'b10:   fifo_count_d = fifo_count_q + CW'(1);
            2'b01:   fifo_count_d = fifo_count_q - CW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase

        if (abort) begin
            vld_d        = '0;
            inflight_d   = '0;
            fifo_push    = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fifo_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tmo_q        <= '0;
            start_q      <= '0;
            addr_q       <= '0;
            chsel_q      <= '0;
            mask_q       <= '0;
            nsmp_q       <= '0;
            remain_q     <= '0;
            vld_q        <= '0;
            inflight_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            start_q      <= start_d;
            addr_q       <= addr_d;
            chsel_q      <= chsel_d;
            mask_q       <= mask_d;
            nsmp_q       <= nsmp_d;
            remain_q     <= remain_d;
            vld_q        <= vld_d;
            inflight_q   <= inflight_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push && !reset) fifo_mem_q[wr_ptr_q] <= push_byte;
    end

    // ------------------------------------------------------------ outputs
    // Everything is forced low while reset is held, independent of the
    // state left over from before the reset edge.
    assign busy         = !reset && (state_q != S_IDLE);
    assign startTrigger = !reset && start_trig_c;
    assign rden         = !reset && rden_c;
    assign done         = !reset && done_c;
    assign timed_out    = !reset && timeout_c;
    assign rdaddress    = reset ? '0 : addr_q;
    assign chsel        = reset ? 2'b00 : chsel_q;
    assign out_valid    = !reset && (fifo_count_q != '0);
    assign out_data     = reset ? 8'h00 : fifo_mem_q[rd_ptr_q];

endmodule
